down_counter: RTL and testbench
===============================

Name: down_counter

Overview:
- Decrementing counterpart to the team's up-counter.
- Holds a loaded credit or work count and consumes it by a variable amount per enabled cycle.
- Flags exhaustion with a one-cycle done pulse and flags over-consumption with a sticky underflow error.
- Sits on the consumer side of credit/token paths, draining what the incrementing counter accumulates.

Parameters:
CNT_DEC_SIZE, 2, width of the per-cycle decrement input dec
CNT_SIZE, 16, width of the count value

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
clear  input  1  zero the count, drop the error, return to IDLE
load  input  1  load load_value into the count
load_value  input  CNT_SIZE  value captured when load=1
en  input  1  apply one decrement this cycle
dec  input  CNT_DEC_SIZE  unsigned amount subtracted when en=1
zero_value  output  1  combinational, high when value==0
busy  output  1  registered, high in state RUN
done  output  1  registered one-cycle pulse on a decrement that reaches exactly zero
error_underflow  output  1  registered, sticky, high in state ERR
value  output  CNT_SIZE  current count

Behaviour:
- One clock, clk. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - value=0, state=IDLE
  - busy=0, done=0, error_underflow=0
  - zero_value=1
- Command priority, per cycle: reset > clear > load > en. Lower-priority commands are ignored in a cycle where a higher one is active.
- Arithmetic:
  - diff = {1'b0,value} - zero-extended dec, computed at CNT_SIZE+1 bits.
  - borrow = diff[CNT_SIZE].
  - On en, value <= diff[CNT_SIZE-1:0]. Wrap-around on borrow is intentional and deterministic.
  - dec=0 with en=1 is a no-op on value and raises no done or error.
- States: IDLE (value==0, no error), RUN (value!=0, no error), ERR (underflow seen).
- clear, from any state: value<=0, next state IDLE.
- load, from any state: value<=load_value; next state RUN if load_value!=0, else IDLE. load also clears the error.
- IDLE + en:
  - dec==0: stay in IDLE.
  - dec!=0: borrow, so value wraps and next state is ERR.
- RUN + en:
  - borrow: next state ERR, value wraps, no done.
  - diff==0 with no borrow: next state IDLE and done=1 for exactly the next cycle.
  - otherwise: stay in RUN.
- ERR + en: value keeps decrementing and wrapping. Only clear, load or reset leave ERR. done is never asserted in ERR.
- Output timing:
  - done is high only in the cycle after the qualifying edge.
  - done is 0 whenever clear, load or reset is active on the edge.
- busy and error_underflow are decoded from the registered state, so they reflect the state after the edge. zero_value reflects the registered value.
- Simultaneous load and en: load wins and the decrement is dropped.
- Simultaneous clear and load: clear wins.
- Reset mid-operation (any state, en active): the reset values above apply on that edge, with no done and no error.
- No backpressure: every enabled cycle is consumed. Upstream must not exceed the loaded budget, or ERR is entered.

Test Plan:
- Reset, then idle 3 cycles -> value=0, zero_value=1, busy=0, done=0, error_underflow=0 throughout.
- load=1, load_value=5; then en=1 with dec=2,2,1 -> value 5,3,1,0; busy=1 until the last edge; done=1 for exactly one cycle after value reaches 0; state IDLE, error_underflow=0.
- load_value=3; en with dec=2,2 -> value 3,1,0xFFFF; error_underflow=1 and busy=0 after the second decrement; no done. A further en with dec=1 -> value 0xFFFE, error still 1.
- In ERR, load=1 with load_value=0x0010 and en=1 dec=3 in the same cycle -> value=0x0010, error_underflow=0, busy=1, decrement ignored. Next cycle clear=1 and load=1 -> value=0, IDLE.
- From IDLE (value=0), en=1 dec=0 -> no change, no done, no error. Then en=1 dec=1 -> value=0xFFFF, error_underflow=1.
- load_value=4, en with dec=1; assert reset on the edge where value would go 2->1 -> value=0, all flags 0 next cycle. Same scenario with CNT_SIZE=4, CNT_DEC_SIZE=3: load 7, dec=7 -> done pulse; dec=7 again -> value=9, error set.

Source files
------------

// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable credit down-counter with done pulse and sticky underflow
module down_counter #(
  parameter int CNT_DEC_SIZE = 2,
  parameter int CNT_SIZE     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    load,
  input  logic [CNT_SIZE-1:0]     load_value,
  input  logic                    en,
  input  logic [CNT_DEC_SIZE-1:0] dec,
  output logic                    zero_value,
  output logic                    busy,
  output logic                    done,
  output logic                    error_underflow,
  output logic [CNT_SIZE-1:0]     value
);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  state_t            state;
  logic [CNT_SIZE:0] diff;
  logic              borrow;
  logic              diff_zero;

  // One extra bit catches the borrow; the low bits are the wrapped result.
  assign diff      = {1'b0, value} - {{(CNT_SIZE + 1 - CNT_DEC_SIZE){1'b0}}, dec};
  assign borrow    = diff[CNT_SIZE];
  assign diff_zero = (diff[CNT_SIZE-1:0] == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        value <= '0;
        state <= IDLE;
      end else if (load) begin
        value <= load_value;
        state <= (load_value != '0) ? RUN : IDLE;
      end else if (en) begin
        value <= diff[CNT_SIZE-1:0];
        case (state)
          IDLE, RUN: begin
            if (borrow) begin
              state <= ERR;
            end else if (diff_zero && (dec != '0)) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          ERR:     state <= ERR;
          default: state <= ERR;
        endcase
      end
    end
  end

  assign busy            = (state == RUN);
  assign error_underflow = (state == ERR);
  assign zero_value      = (value == '0);

endmodule

// File: tb/tb_down_counter.sv
// tb/tb_down_counter.sv - self-checking bench for down_counter at two widths
module tb_down_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_clear, a_load, a_en;
  logic [15:0] a_load_value, a_value;
  logic [1:0]  a_dec;
  logic        a_zero, a_busy, a_done, a_err;
  logic        b_clear, b_load, b_en;
  logic [3:0]  b_load_value, b_value;
  logic [2:0]  b_dec;
  logic        b_zero, b_busy, b_done, b_err;

  down_counter #(.CNT_DEC_SIZE(2), .CNT_SIZE(16)) dut_a (
    .clk(clk), .reset(reset), .clear(a_clear), .load(a_load), .load_value(a_load_value),
    .en(a_en), .dec(a_dec), .zero_value(a_zero), .busy(a_busy), .done(a_done),
    .error_underflow(a_err), .value(a_value));

  down_counter #(.CNT_DEC_SIZE(3), .CNT_SIZE(4)) dut_b (
    .clk(clk), .reset(reset), .clear(b_clear), .load(b_load), .load_value(b_load_value),
    .en(b_en), .dec(b_dec), .zero_value(b_zero), .busy(b_busy), .done(b_done),
    .error_underflow(b_err), .value(b_value));

  int n_assert = 0;
  int n_fail   = 0;

  // Reference: count as plain integers modulo 2**width, error as a flag.
  longint mv[2];
  bit     merr[2];
  bit     mdone[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int j, input bit r, input bit c, input bit l,
                       input longint lv, input bit e, input longint d);
    longint modv, nv;
    modv = (j == 0) ? 65536 : 16;
    mdone[j] = 1'b0;
    if (r || c) begin
      mv[j] = 0;
      merr[j] = 1'b0;
    end else if (l) begin
      mv[j] = lv % modv;
      merr[j] = 1'b0;
    end else if (e) begin
      nv = mv[j] - d;
      if (nv < 0) begin
        nv = nv + modv;
        merr[j] = 1'b1;
      end else if (!merr[j] && d != 0 && nv == 0) begin
        mdone[j] = 1'b1;
      end
      mv[j] = nv;
    end
  endtask

  task automatic step(input int k, input bit r, input bit c, input bit l,
                      input int unsigned lv, input bit e, input int unsigned d);
    longint dk;
    reset = r;
    a_clear = 0; a_load = 0; a_load_value = '0; a_en = 0; a_dec = '0;
    b_clear = 0; b_load = 0; b_load_value = '0; b_en = 0; b_dec = '0;
    if (k == 0) begin
      a_clear = c; a_load = l; a_load_value = lv[15:0]; a_en = e; a_dec = d[1:0];
    end else begin
      b_clear = c; b_load = l; b_load_value = lv[3:0]; b_en = e; b_dec = d[2:0];
    end
    @(posedge clk);
    for (int j = 0; j < 2; j++) begin
      dk = (j == 0) ? longint'(d % 4) : longint'(d % 8);
      if (j == k) model(j, r, c, l, longint'(lv), e, dk);
      else        model(j, r, 0, 0, 0, 0, 0);
    end
    #1;
    chk("a_value", {16'h0, a_value}, mv[0][31:0]);
    chk("a_zero",  {31'h0, a_zero},  {31'h0, mv[0] == 0});
    chk("a_busy",  {31'h0, a_busy},  {31'h0, !merr[0] && mv[0] != 0});
    chk("a_done",  {31'h0, a_done},  {31'h0, mdone[0]});
    chk("a_err",   {31'h0, a_err},   {31'h0, merr[0]});
    chk("b_value", {28'h0, b_value}, mv[1][31:0]);
    chk("b_zero",  {31'h0, b_zero},  {31'h0, mv[1] == 0});
    chk("b_busy",  {31'h0, b_busy},  {31'h0, !merr[1] && mv[1] != 0});
    chk("b_done",  {31'h0, b_done},  {31'h0, mdone[1]});
    chk("b_err",   {31'h0, b_err},   {31'h0, merr[1]});
  endtask

  initial begin
    bit r, c, l, e;
    int k;
    int unsigned lv, d;

    step(0, 1, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);

    // Exact drain to zero with a done pulse
    step(0, 0, 0, 1, 5, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    // Over-consumption wraps and sticks in error
    step(0, 0, 0, 1, 3, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 1, 1);

    // load beats en; clear beats load
    step(0, 0, 0, 1, 16'h0010, 1, 3);
    step(0, 0, 1, 1, 16'h0020, 0, 0);

    // Idle zero-decrement no-op, then underflow from idle
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);

    // Reset mid-run
    step(0, 0, 0, 1, 4, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    // Narrow instance: full-width decrement hits zero, then wraps to 9
    step(1, 0, 0, 1, 7, 0, 0);
    step(1, 0, 0, 0, 0, 1, 7);
    step(1, 0, 0, 0, 0, 1, 7);
    step(1, 0, 0, 0, 0, 0, 0);

    repeat (400) begin
      k = $urandom_range(0, 1);
      r = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 6) == 0);
      e = ($urandom_range(0, 3) != 0);
      lv = ($urandom_range(0, 2) == 0) ? $urandom : $urandom_range(0, 9);
      d = $urandom;
      step(k, r, c, l, lv, e, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
